serial_mag_cmp: RTL and testbench
=================================

Name: serial_mag_cmp

Overview:
- Parametrised, sequential successor to the team's combinational 5-bit G/L/E magnitude comparator.
- Compares two W-bit operands MSB-first, D bits per clock.
- Terminates early on the first differing digit and supports unsigned or two's-complement mode per operation.
- Used wherever a wide compare must trade latency for area, behind a start/done handshake.

Parameters:
- W, 8, operand width in bits; W >= 2.
- D, 1, bits examined per cycle (digit width); 1 <= D <= W; W must be a multiple of D.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  W  operand A; captured with start.
- b  input  W  operand B; captured with start.
- busy  output  1  high while an operation is in progress (SCAN or DONE).
- done  output  1  single-cycle completion pulse.
- gt  output  1  A > B result.
- lt  output  1  A < B result.
- eq  output  1  A == B result.

Behaviour:
- Reset (rst_n low, asynchronous, any state): FSM goes to IDLE, digit index is 0, captured operands are 0, and busy=done=gt=lt=eq=0. All of this happens immediately, without a clock edge. An operation interrupted mid-scan is discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - busy=0, done=0.
  - A clock edge with start=1 does all of the following: captures a, b and signed_mode into internal registers; sets the digit index to W/D-1; clears gt, lt and eq to 0; moves to SCAN.
  - If signed_mode=1, bit W-1 of both captured operands is inverted at capture. All later comparison is unsigned.
- SCAN (busy=1): each cycle, compare captured digits [idx*D+D-1 : idx*D] as unsigned D-bit values.
  - A digit > B digit: set gt=1 and move to DONE.
  - A digit < B digit: set lt=1 and move to DONE.
  - Digits equal and idx==0: set eq=1 and move to DONE.
  - Digits equal and idx>0: decrement idx and stay in SCAN.
- DONE (busy=1, done=1 for exactly this one cycle): next edge moves to IDLE unconditionally.
- Result outputs:
  - Exactly one of gt/lt/eq is high from DONE onward.
  - They hold through IDLE until the next start is accepted.
  - All three are 0 after reset and during SCAN.
- Latency: let the start-accepting edge be edge 0 and n the number of digits examined, 1 <= n <= W/D.
  - SCAN occupies cycles 1..n.
  - done is high in cycle n+1.
  - busy is high in cycles 1..n+1.
  - Best case (MSB digit differs): done in cycle 2.
  - Worst case (equal, or LSB digit differs): done in cycle W/D+1.
- Inputs during an operation:
  - start while busy=1 is ignored, with no queuing.
  - Changes on a, b or signed_mode after capture have no effect on the current operation.
  - A new start may be accepted the cycle immediately after DONE, i.e. the first IDLE cycle.
- Index counter width is max(1, clog2(W/D)). No wrap-around: idx never decrements below 0.
- Outputs are registered: no combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → busy=done=gt=lt=eq=0 throughout. Release rst_n with start=0 → still idle.
- W=8, D=1, unsigned, a=0xA5, b=0x25 → gt=1, lt=eq=0, done pulses in cycle 2 after the start edge, busy high cycles 1–2. Then a=b=0x3C → eq=1, done in cycle 9.
- W=8, D=1, a=0x80, b=0x01:
  - signed_mode=1 → lt=1, done cycle 2.
  - Repeat with signed_mode=0 → gt=1.
  - Signed a=0xFF, b=0xFE → gt=1, done cycle 9.
- Handshake robustness: a=0x12, b=0x13 unsigned. Pulse start again and change a to 0xFF during cycles 3–6 → single done in cycle 9 with lt=1, and the second start is ignored. A start in the first IDLE cycle after DONE is accepted.
- Reset mid-operation: start a=0x00, b=0x00, then drive rst_n low in cycle 4 → busy and results drop to 0 asynchronously, no done pulse. After release, a new start with a=0x01, b=0x00 → gt=1 in cycle 9.
- Parametrised W=16, D=4: a=0x5A3C, b=0x5A3D → lt=1, done cycle 5. a=0x7000, b=0x6FFF → gt=1, done cycle 2.

Source files
------------

// File: rtl/serial_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : serial_mag_cmp
//  Description : Sequential magnitude comparator. Scans two W-bit operands
//                MSB-first, D bits per clock. It stops at the first digit
//                that differs and reports gt/lt/eq behind a start/done
//                handshake. Supports unsigned or two's-complement compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_cmp #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         signed_mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);

    localparam int NDIG = W / D;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [W-1:0]  a_q,     a_d;
    logic [W-1:0]  b_q,     b_d;
    logic          gt_q,    gt_d;
    logic          lt_q,    lt_d;
    logic          eq_q,    eq_d;

    logic [D-1:0]  dig_a, dig_b;
    logic [W-1:0]  sign_flip;

    // Flipping the sign bit of both operands maps two's-complement ordering
    // onto unsigned ordering, so the scan itself is always unsigned.
    assign sign_flip = {signed_mode_i, {(W-1){1'b0}}};

    // Digit currently under examination.
    assign dig_a = a_q[int'(idx_q)*D +: D];
    assign dig_b = b_q[int'(idx_q)*D +: D];

    // State, index, operand and result registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    // Next-state logic: capture on start, scan MSB-first, stop on first difference.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i ^ sign_flip;
                    b_d     = b_i ^ sign_flip;
                    idx_d   = IW'(NDIG - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dig_a > dig_b) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (dig_a < dig_b) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state.
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign gt_o   = gt_q;
    assign lt_o   = lt_q;
    assign eq_o   = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_mag_cmp
//  Description : Self-checking bench for serial_mag_cmp. Drives an 8-bit
//                D=1 instance and a 16-bit D=4 instance. Checks results,
//                done timing, busy window and result hold against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_cmp;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, gt8, lt8, eq8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, gt16, lt16, eq16;

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    logic       busy_m, done_m;
    logic [2:0] res_m;

    always #5 clk = ~clk;

    serial_mag_cmp #(.W(8), .D(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .signed_mode_i(sm8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
        .gt_o(gt8), .lt_o(lt8), .eq_o(eq8)
    );

    serial_mag_cmp #(.W(16), .D(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start16), .signed_mode_i(sm16),
        .a_i(a16), .b_i(b16), .busy_o(busy16), .done_o(done16),
        .gt_o(gt16), .lt_o(lt16), .eq_o(eq16)
    );

    assign busy_m = (cur != 0) ? busy16 : busy8;
    assign done_m = (cur != 0) ? done16 : done8;
    assign res_m  = (cur != 0) ? {gt16, lt16, eq16} : {gt8, lt8, eq8};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: compare as integers; n = digits scanned from the top up to
    // and including the first differing one (all digits when equal).
    function automatic void ref_cmp(input int w, input int d, input logic [15:0] a,
                                    input logic [15:0] b, input logic sm,
                                    output logic [2:0] res, output int n);
        longint va, vb;
        int     ia, ib, mask;
        va = longint'(a);
        vb = longint'(b);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        res  = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
        ia   = int'(a);
        ib   = int'(b);
        mask = (1 << d) - 1;
        n    = 0;
        for (int i = w/d - 1; i >= 0; i--) begin
            n++;
            if (((ia >> (i*d)) & mask) != ((ib >> (i*d)) & mask)) break;
        end
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start16 = v; else start8 = v;
    endtask

    // Called at a negedge; start is accepted on the following posedge.
    // Returns at the negedge of the first IDLE cycle after done.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input bit glitch);
        logic [2:0] exp_res, res_done;
        int         n, done_k, done_cnt;
        bit         busy_ok, scan_ok;
        cur = sel;
        ref_cmp((sel != 0) ? 16 : 8, (sel != 0) ? 4 : 1, a, b, sm, exp_res, n);
        if (sel != 0) begin
            a16 = a; b16 = b; sm16 = sm;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
        end
        set_start(sel, 1'b1);
        @(posedge clk);
        done_k = 0; done_cnt = 0; busy_ok = 1'b1; scan_ok = 1'b1; res_done = '0;
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (done_m) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (k <= n + 1) begin
                if (busy_m !== 1'b1) busy_ok = 1'b0;
            end
            if (k <= n && res_m !== 3'b000) scan_ok = 1'b0;
            if (k == n + 1) res_done = res_m;
            if (k == n + 2) begin
                check("idle_busy", 32'(busy_m), 32'd0);
                check("hold", 32'(res_m), 32'(exp_res));
            end
            if (glitch && k >= 3 && k <= 6) begin
                set_start(sel, 1'b1);
                a8 = 8'hFF;
            end else begin
                set_start(sel, 1'b0);
            end
        end
        check("done_cycle", 32'(done_k), 32'(n + 1));
        check("done_count", 32'(done_cnt), 32'd1);
        check("busy_window", 32'(busy_ok), 32'd1);
        check("scan_res_zero", 32'(scan_ok), 32'd1);
        check("result", 32'(res_done), 32'(exp_res));
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          sel, w;
        logic        rsm;

        // Reset held with start asserted.
        start8 = 1'b1; a8 = 8'hA5; b8 = 8'h25;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
        end
        rst_n  = 1'b1;
        start8 = 1'b0;
        @(negedge clk);
        check("rst_idle", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);

        // Directed 8-bit cases, issued back-to-back so each new start lands
        // on the first IDLE cycle after the previous done.
        run_op(0, 16'h00A5, 16'h0025, 1'b0, 1'b0);
        run_op(0, 16'h003C, 16'h003C, 1'b0, 1'b0);
        run_op(0, 16'h0080, 16'h0001, 1'b1, 1'b0);
        run_op(0, 16'h0080, 16'h0001, 1'b0, 1'b0);
        run_op(0, 16'h00FF, 16'h00FE, 1'b1, 1'b0);
        run_op(0, 16'h0012, 16'h0013, 1'b0, 1'b1);
        run_op(0, 16'h0040, 16'h0041, 1'b0, 1'b0);

        // Reset in the middle of a scan.
        a8 = 8'h00; b8 = 8'h00; sm8 = 1'b0; start8 = 1'b1; cur = 0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_async", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_hold", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 16'h0001, 16'h0000, 1'b0, 1'b0);

        // Directed 16-bit, 4-bit digit cases.
        run_op(1, 16'h5A3C, 16'h5A3D, 1'b0, 1'b0);
        run_op(1, 16'h7000, 16'h6FFF, 1'b0, 1'b0);
        run_op(1, 16'h8000, 16'h7FFF, 1'b1, 1'b0);

        // Randomised cases, biased towards equal and near-equal operands.
        for (int i = 0; i < 60; i++) begin
            sel = i % 2;
            w   = (sel != 0) ? 16 : 8;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (w == 8) begin
                ra[15:8] = '0;
                rb[15:8] = '0;
            end
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'd1 << $urandom_range(0, w - 1));
                default: ;
            endcase
            rsm = 1'($urandom);
            run_op(sel, ra, rb, rsm, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
